dmem_responder: RTL
===================

# dmem_responder

Data-memory responder that sits on the far side of the core's `dmem_*` request/ready interface. It replaces the testbench's zero-latency behavioural memory with a cycle-accurate slave. It latches each request, inserts a configurable number of wait states, performs a byte-masked 64-bit read or write on an internal word array, and answers with a one-cycle `dmem_ready` pulse. It also flags misaligned or out-of-range accesses and keeps access statistics for integration benches and FPGA bring-up.

## Interface

Parameters:
- `XLEN`, default 64: data and address width; only 64 is supported.
- `DEPTH`, default 1024: number of 64-bit words in the array.
- `LATENCY`, default 1, range 0..15: wait-state cycles between request acceptance and the response.
- `BASE_ADDR`, default 0: byte address of word 0.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `dmem_addr`  in  XLEN: byte address of the access.
- `dmem_wdata`  in  XLEN: write data.
- `dmem_wmask`  in  8: byte-lane write enables; bit i enables byte i.
- `dmem_req`  in  1: request; held by the core until `dmem_ready`.
- `dmem_we`  in  1: 1 = write, 0 = read.
- `dmem_rdata`  out  XLEN: read data, registered.
- `dmem_ready`  out  1: one-cycle response strobe.
- `dmem_err`  out  1: access error; valid only while `dmem_ready`=1.
- `rd_count`  out  32: completed reads, including errored reads.
- `wr_count`  out  32: completed writes, including errored writes.
- `err_count`  out  32: errored accesses.

## Operation

- FSM has three states: IDLE, WAIT, RESP.
- **IDLE.** When `dmem_req`=1, latch addr, wdata, wmask and we.
  - If `LATENCY`=0, go to RESP.
  - Otherwise load the wait counter with `LATENCY` and go to WAIT.
- **WAIT.** Decrement the counter each cycle; go to RESP on the edge where the counter reaches 1.
- **RESP.** Drive `dmem_ready`=1 for exactly one cycle, then go to IDLE unconditionally.
- Request inputs that change after acceptance are ignored; only the latched copy is used.
- Address decode: offset = addr − `BASE_ADDR`, index = offset >> 3.
- Error conditions:
  - addr[2:0] ≠ 0 (misaligned), or
  - addr < `BASE_ADDR`, or
  - offset ≥ `DEPTH`·8.
- The array access happens on the clock edge that enters RESP.
  - Read: `dmem_rdata` ← word[index].
  - Write: word[index] byte i ← wdata byte i for each set wmask bit; `dmem_rdata` ← 0.
  - wmask = 0: the write completes with no bytes changed.
- Error access: no array access, `dmem_rdata` ← 0, `dmem_err`=1 during RESP, and `err_count` increments.
- `dmem_rdata` holds its value until the next entry into RESP.
- Counters:
  - Each counter increments by 1 on the edge leaving RESP.
  - Exactly one of `rd_count`/`wr_count` increments per transaction, per the latched we.
  - All counters saturate at 0xFFFF_FFFF.
- Array contents are not cleared by reset; they persist across `rst`.

## Timing

- Reset values: state IDLE, `dmem_ready`=0, `dmem_err`=0, `dmem_rdata`=0, all counters 0, wait counter 0.
- Reset mid-transaction (WAIT or RESP): abort immediately and go to IDLE.
  - No ready pulse is produced for the aborted request.
  - A write whose RESP edge had not yet occurred is not committed.
  - Counters return to 0.
- Latency: request sampled in IDLE at cycle 0 → `dmem_ready` high in cycle `LATENCY`+1.
- Throughput: one transaction per `LATENCY`+2 cycles, because there is a mandatory IDLE cycle after RESP.
- If `dmem_req` is still 1 in the IDLE cycle after RESP, it is accepted as a new request with the inputs present in that cycle.
- `dmem_ready` and `dmem_err` are registered outputs and never combinationally depend on `dmem_req`.
- `dmem_err` is 0 in every cycle where `dmem_ready`=0.

## Test plan

- **Basic write then read** (`LATENCY`=1, `BASE_ADDR`=0):
  - Write 0x1122334455667788 to 0x40, wmask 0xFF, req at cycle 0 → `dmem_ready`=1 in cycle 2, `dmem_err`=0.
  - Read of 0x40 → `dmem_rdata`=0x1122334455667788; `wr_count`=1, `rd_count`=1.
- **Partial write:**
  - Write 0xAAAAAAAABBBBBBBB to 0x40 with wmask 0x0F.
  - Read 0x40 → 0x11223344BBBBBBBB.
- **Error accesses:**
  - Read 0x44 (misaligned) → `dmem_ready`=1, `dmem_err`=1, `dmem_rdata`=0.
  - Write to 0x2000 (= `DEPTH`·8) → `dmem_err`=1.
  - Then `err_count`=2, and a read of 0x40 is still 0x11223344BBBBBBBB.
- **Back-to-back reads** (`LATENCY`=3, `dmem_req` held high across two reads):
  - Ready pulses in cycles 4 and 9.
  - Each pulse is exactly one cycle wide; `rd_count`=2.
- **`LATENCY`=0:**
  - Read accepted in cycle 0 → ready in cycle 1.
  - Holding req continuously gives a pulse every 2 cycles.
- **Reset mid-operation:**
  - Assert `rst` during WAIT of a write of 0xDEAD to 0x80 → all outputs 0 asynchronously and no ready pulse.
  - After release, a read of 0x80 returns its pre-write value.
  - A read of 0x40 still returns 0x11223344BBBBBBBB.

Source files
------------

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//
// Request/response bundle between a core's data-memory port and the
// dmem_responder slave.
//
// Handshake: the master raises dmem_req together with dmem_addr, dmem_we,
// dmem_wdata and dmem_wmask, and holds dmem_req until it sees dmem_ready
// high for one cycle. dmem_ready is a single-cycle strobe. dmem_rdata and
// dmem_err are meaningful only in that cycle. There is no back-pressure on
// the response; the master must accept it.
//
// Signals:
//   dmem_addr   master->slave  XLEN  byte address
//   dmem_wdata  master->slave  XLEN  write data
//   dmem_wmask  master->slave  8     byte-lane write enables
//   dmem_req    master->slave  1     request, held until dmem_ready
//   dmem_we     master->slave  1     1 = write, 0 = read
//   dmem_rdata  slave->master  XLEN  read data
//   dmem_ready  slave->master  1     one-cycle response strobe
//   dmem_err    slave->master  1     access error, qualified by dmem_ready
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [7:0]      dmem_wmask;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ready;
    logic            dmem_err;

    modport master (
        output dmem_addr, dmem_wdata, dmem_wmask, dmem_req, dmem_we,
        input  dmem_rdata, dmem_ready, dmem_err
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_wmask, dmem_req, dmem_we,
        output dmem_rdata, dmem_ready, dmem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Cycle-accurate data-memory slave. Latches a request, waits LATENCY cycles,
// performs a byte-masked 64-bit read or write on an internal word array and
// answers with a one-cycle dmem_ready strobe. Misaligned or out-of-range
// accesses are answered with dmem_err and do not touch the array. Completed
// reads, writes and errors are counted with saturating counters.
//
// Parameters:
//   XLEN       data/address width (only 64 supported)
//   DEPTH      number of 64-bit words in the array (>= 2)
//   LATENCY    wait-state cycles, 0..15
//   BASE_ADDR  byte address of word 0
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   dmem       slave side of dmem_responder_if
//   rd_count   completed reads (errored ones included)
//   wr_count   completed writes (errored ones included)
//   err_count  errored accesses
//   state_dbg  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Timing: request sampled in IDLE in cycle 0 -> dmem_ready in cycle
// LATENCY+1, followed by a mandatory IDLE cycle.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int              XLEN      = 64,
    parameter int              DEPTH     = 1024,
    parameter int              LATENCY   = 1,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_responder_if.slave      dmem,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count,
    output logic [31:0]          err_count,
    output logic [1:0]           state_dbg
);

    localparam int              IDX_W = $clog2(DEPTH);
    localparam logic [XLEN-1:0] SPAN  = XLEN'(DEPTH) << 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [3:0]      wait_cnt, wait_cnt_next;
    logic            take_req;

    // Latched request.
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [7:0]      wmask_q;
    logic            we_q;

    // Registered response.
    logic [XLEN-1:0] rdata_q;
    logic            ready_q;
    logic            err_q;

    // Access operands. With LATENCY=0 the array access happens on the same
    // edge that accepts the request, so the live inputs must be used while in
    // IDLE; from WAIT only the latched copy is used.
    logic [XLEN-1:0] acc_addr;
    logic [XLEN-1:0] acc_wdata;
    logic [7:0]      acc_wmask;
    logic            acc_we;
    logic [XLEN-1:0] acc_off;
    logic            acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic            enter_resp;
    logic            mem_wr;

    logic [63:0]     mem [DEPTH];

    // ---------------------------------------------------------------- FSM next
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        take_req      = 1'b0;
        case (state)
            S_IDLE: begin
                if (dmem.dmem_req) begin
                    take_req = 1'b1;
                    if (LATENCY == 0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = 4'(LATENCY);
                    end
                end
            end
            S_WAIT: begin
                // Leave on the edge where the counter reaches its last count.
                if (wait_cnt <= 4'd1) begin
                    state_next    = S_RESP;
                    wait_cnt_next = 4'd0;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next    = S_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------ access decode
    always_comb begin
        if (state == S_IDLE) begin
            acc_addr  = dmem.dmem_addr;
            acc_wdata = dmem.dmem_wdata;
            acc_wmask = dmem.dmem_wmask;
            acc_we    = dmem.dmem_we;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wmask = wmask_q;
            acc_we    = we_q;
        end
    end

    assign acc_off    = acc_addr - BASE_ADDR;
    assign acc_idx    = acc_off[IDX_W+2:3];
    assign acc_err    = (acc_addr[2:0] != 3'd0) ||
                        (acc_addr < BASE_ADDR)   ||
                        (acc_off >= SPAN);
    assign enter_resp = (state != S_RESP) && (state_next == S_RESP);
    // Gated by rst so an aborted transaction can never commit a write.
    assign mem_wr     = enter_resp && acc_we && !acc_err && !rst;

    // ------------------------------------------------------- state and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= 8'd0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_count  <= 32'd0;
            wr_count  <= 32'd0;
            err_count <= 32'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;

            if (take_req) begin
                addr_q  <= dmem.dmem_addr;
                wdata_q <= dmem.dmem_wdata;
                wmask_q <= dmem.dmem_wmask;
                we_q    <= dmem.dmem_we;
            end

            ready_q <= enter_resp;
            err_q   <= enter_resp && acc_err;

            // rdata holds until the next entry into RESP.
            if (enter_resp) begin
                if (acc_err || acc_we) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= mem[acc_idx];
                end
            end

            // Statistics update on the edge leaving RESP.
            if (state == S_RESP) begin
                if (we_q) begin
                    if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
                end else begin
                    if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
                end
                if (err_q && (err_count != 32'hFFFF_FFFF)) begin
                    err_count <= err_count + 32'd1;
                end
            end
        end
    end

    // Array has no reset: contents persist across rst.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 8; b++) begin
                if (acc_wmask[b]) begin
                    mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign dmem.dmem_rdata = rdata_q;
    assign dmem.dmem_ready = ready_q;
    assign dmem.dmem_err   = err_q;
    assign state_dbg       = state;

endmodule
